fetch_stage: RTL and testbench

- IF stage of the 5-stage core; sits directly upstream of decode.
- Owns the fetch PC and drives a synchronous-read instruction memory (1-cycle read latency).
- Presents instruction, curr_pc and next_pc to decode, inserting NOP bubbles on redirect.
- Handles the stall, flush/branch redirect, interrupt entry (saves EPC, jumps to the vector) and rti return.

---
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: IF stage of the 5-stage core, directly upstream of decode.
// Owns the fetch PC (pc_f) and drives a synchronous-read instruction memory
// with 1-cycle read latency. It presents instruction/curr_pc/next_pc to
// decode, inserts NOP bubbles on redirect, and handles stalls, EX redirects,
// interrupt entry (EPC save + vector jump) and rti return.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   hazard                  load-use stall from decode (hold IF and ID)
//   stall_mem               memory stall (freeze all state)
//   flush, branch_target    EX redirect and its target address
//   rti                     EX executing rti, qualified by flush
//   interrupt               external interrupt request (level or pulse)
//   interrupt_branch_alert  decode holds a branch/jalr in ID
//   imem_rdata              memory data for last cycle's imem_addr
//   imem_addr               fetch address (pc_f register)
//   instruction             instruction in ID (NOP when ID is empty)
//   curr_pc, next_pc        PC of the ID instruction and PC + 4
//   int_flush               squash ID this cycle (interrupt being taken)
//   int_active, epc         ISR in progress, saved return PC
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ISR_VECTOR = 32'h0000_0100,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard,
  input  logic        stall_mem,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic        rti,
  input  logic        interrupt,
  input  logic        interrupt_branch_alert,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] instruction,
  output logic [31:0] curr_pc,
  output logic [31:0] next_pc,
  output logic        int_flush,
  output logic        int_active,
  output logic [31:0] epc
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] curr_pc_q, curr_pc_d;
  logic [XLEN-1:0] hold_reg_q, hold_reg_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            valid_id_q, valid_id_d;
  logic            held_q, held_d;
  logic            int_active_q, int_active_d;
  logic            int_pending_q, int_pending_d;

  logic stall;
  logic int_take;

  // Stall and interrupt-take qualification
  always_comb begin
    stall    = hazard | stall_mem;
    int_take = int_pending_q & ~int_active_q & valid_id_q & ~stall & ~flush &
               ~interrupt_branch_alert;
  end

  // Next-state logic, in update priority order
  always_comb begin
    pc_f_d        = pc_f_q;
    curr_pc_d     = curr_pc_q;
    hold_reg_d    = hold_reg_q;
    epc_d         = epc_q;
    valid_id_d    = valid_id_q;
    held_d        = held_q;
    int_active_d  = int_active_q;
    int_pending_d = int_pending_q | interrupt;

    if (!stall_mem) begin
      if (flush && rti) begin
        pc_f_d       = epc_q;
        int_active_d = 1'b0;
        valid_id_d   = 1'b0;
      end else if (flush) begin
        pc_f_d     = branch_target;
        valid_id_d = 1'b0;
      end else if (int_take) begin
        pc_f_d        = ISR_VECTOR;
        epc_d         = curr_pc_q;
        int_active_d  = 1'b1;
        int_pending_d = 1'b0;
        valid_id_d    = 1'b0;
      end else if (!hazard) begin
        curr_pc_d  = pc_f_q;
        pc_f_d     = pc_f_q + PC_STEP;
        valid_id_d = 1'b1;
      end
    end

    // Keep the stalled ID instruction once memory output moves on to pc_f
    if (stall && !held_q && valid_id_q) begin
      hold_reg_d = imem_rdata;
      held_d     = 1'b1;
    end else if (!stall) begin
      held_d = 1'b0;
    end
    if (!stall_mem && (flush || int_take)) begin
      held_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f_q        <= RESET_PC;
      curr_pc_q     <= '0;
      hold_reg_q    <= '0;
      epc_q         <= '0;
      valid_id_q    <= 1'b0;
      held_q        <= 1'b0;
      int_active_q  <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      pc_f_q        <= pc_f_d;
      curr_pc_q     <= curr_pc_d;
      hold_reg_q    <= hold_reg_d;
      epc_q         <= epc_d;
      valid_id_q    <= valid_id_d;
      held_q        <= held_d;
      int_active_q  <= int_active_d;
      int_pending_q <= int_pending_d;
    end
  end

  // Output drive
  always_comb begin
    imem_addr   = pc_f_q;
    curr_pc     = curr_pc_q;
    next_pc     = curr_pc_q + PC_STEP;
    int_flush   = int_take;
    int_active  = int_active_q;
    epc         = epc_q;
    if (!valid_id_q) begin
      instruction = NOP;
    end else if (held_q) begin
      instruction = hold_reg_q;
    end else begin
      instruction = imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The memory model returns addr+1 for every
// word (mem[i] = i*4+1), so the instruction for any PC is PC+1. Expected ID
// presentations are queued by the stimulus; a negedge monitor pops one entry
// for every cycle ID shows a non-NOP instruction.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
  } id_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard, stall_mem, flush, rti, interrupt, interrupt_branch_alert;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr, instruction, curr_pc, next_pc, epc;
  logic        int_flush, int_active;

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  id_t  exp_q[$];
  id_t  mon_e;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .ISR_VECTOR(32'h0000_0100),
    .NOP       (NOP)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .hazard                (hazard),
    .stall_mem             (stall_mem),
    .flush                 (flush),
    .branch_target         (branch_target),
    .rti                   (rti),
    .interrupt             (interrupt),
    .interrupt_branch_alert(interrupt_branch_alert),
    .imem_rdata            (imem_rdata),
    .imem_addr             (imem_addr),
    .instruction           (instruction),
    .curr_pc               (curr_pc),
    .next_pc               (next_pc),
    .int_flush             (int_flush),
    .int_active            (int_active),
    .epc                   (epc)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory, mem[i] = i*4+1
  always @(posedge clk) imem_rdata <= imem_addr + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_id(input logic [31:0] pc);
    id_t e;
    e.pc   = pc;
    e.inst = pc + 32'd1;
    e.npc  = pc + 32'd4;
    exp_q.push_back(e);
  endtask

  // Monitor: every non-NOP ID cycle must match the next queued expectation
  always @(negedge clk) begin
    if (mon_en && instruction !== NOP) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL id_unexpected: got pc=%h inst=%h, required no valid ID", curr_pc, instruction);
      end else begin
        mon_e = exp_q.pop_front();
        if ({curr_pc, instruction, next_pc} !== mon_e) begin
          errors++;
          $display("FAIL id_stream: got pc=%h inst=%h npc=%h, required pc=%h inst=%h npc=%h",
                   curr_pc, instruction, next_pc, mon_e.pc, mon_e.inst, mon_e.npc);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; hazard = 1'b0; stall_mem = 1'b0; flush = 1'b0; rti = 1'b0;
    interrupt = 1'b0; interrupt_branch_alert = 1'b0; branch_target = '0;
    step(); step();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    chk("rst_instruction", instruction, NOP);
    chk("rst_curr_pc", curr_pc, 32'h0);
    chk("rst_next_pc", next_pc, 32'h4);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_int_active", 32'(int_active), 32'h0);
    chk("rst_int_flush", 32'(int_flush), 32'h0);

    // Sequential fetch, then a 2-cycle hazard on PC 8
    step(); expect_id(32'h0);
    step(); expect_id(32'h4);
    step(); expect_id(32'h8); hazard = 1'b1;
    step(); expect_id(32'h8);
    step(); expect_id(32'h8); hazard = 1'b0;
    step(); expect_id(32'hC);
    step(); expect_id(32'h10); flush = 1'b1; branch_target = 32'h40;

    // Redirect to 0x40: one bubble, then target
    step(); flush = 1'b0;
    chk("flush_imem_addr", imem_addr, 32'h40);
    chk("flush_bubble", instruction, NOP);
    step(); expect_id(32'h40); flush = 1'b1; branch_target = 32'h20;
    step(); flush = 1'b0; interrupt = 1'b1;

    // Interrupt taken on PC 0x20
    step(); interrupt = 1'b0; expect_id(32'h20);
    chk("int_flush_take", 32'(int_flush), 32'h1);
    step();
    chk("int_epc", epc, 32'h20);
    chk("int_active_set", 32'(int_active), 32'h1);
    chk("int_flush_after", 32'(int_flush), 32'h0);
    chk("int_vector_addr", imem_addr, 32'h100);
    chk("int_bubble", instruction, NOP);
    step(); expect_id(32'h100); interrupt = 1'b1;
    step(); interrupt = 1'b0; expect_id(32'h104);
    chk("no_nesting", 32'(int_flush), 32'h0);
    flush = 1'b1; rti = 1'b1;

    // rti returns to EPC; the request raised in the ISR is then taken
    step(); flush = 1'b0; rti = 1'b0;
    chk("rti_int_active", 32'(int_active), 32'h0);
    chk("rti_imem_addr", imem_addr, 32'h20);
    chk("rti_bubble", instruction, NOP);
    step(); expect_id(32'h20);
    chk("pending_take_after_rti", 32'(int_flush), 32'h1);
    step();
    chk("second_int_active", 32'(int_active), 32'h1);
    flush = 1'b1; rti = 1'b1;
    step(); flush = 1'b0; rti = 1'b0;
    chk("second_rti_active", 32'(int_active), 32'h0);
    step(); expect_id(32'h20);
    chk("no_pending_left", 32'(int_flush), 32'h0);
    interrupt = 1'b1; interrupt_branch_alert = 1'b1;

    // Branch in ID defers the take until the redirect target is in ID
    step(); interrupt = 1'b0; expect_id(32'h24);
    chk("branch_alert_defer", 32'(int_flush), 32'h0);
    flush = 1'b1; branch_target = 32'h80;
    step();
    chk("defer_bubble", instruction, NOP);
    flush = 1'b0; interrupt_branch_alert = 1'b0;
    step(); expect_id(32'h80);
    chk("deferred_take", 32'(int_flush), 32'h1);
    step();
    chk("deferred_epc", epc, 32'h80);
    chk("deferred_active", 32'(int_active), 32'h1);
    flush = 1'b1; rti = 1'b1;
    step(); flush = 1'b0; rti = 1'b0;
    step(); expect_id(32'h80);

    // stall_mem blocks a simultaneous flush until released
    stall_mem = 1'b1; flush = 1'b1; branch_target = 32'h200;
    step(); expect_id(32'h80);
    chk("stall_mem_freeze_addr", imem_addr, 32'h84);
    step(); expect_id(32'h80); stall_mem = 1'b0;
    step(); flush = 1'b0;
    chk("stall_release_redirect", imem_addr, 32'h200);
    chk("stall_release_bubble", instruction, NOP);
    step(); expect_id(32'h200); flush = 1'b1; branch_target = 32'hFFFF_FFFC;

    // PC wrap
    step(); flush = 1'b0;
    step(); expect_id(32'hFFFF_FFFC);
    chk("wrap_imem_addr", imem_addr, 32'h0);
    step(); expect_id(32'h0);

    // Reset with saved EPC and live ID discards everything
    @(negedge clk); #1; rst_n = 1'b0;
    step();
    chk("rst2_instruction", instruction, NOP);
    chk("rst2_curr_pc", curr_pc, 32'h0);
    chk("rst2_next_pc", next_pc, 32'h4);
    chk("rst2_epc", epc, 32'h0);
    chk("rst2_imem_addr", imem_addr, 32'h0);
    chk("rst2_int_active", 32'(int_active), 32'h0);

    @(negedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
